// File: rtl/ahb_arbiter_slave_pkg.sv
// Shared AHB types and helpers for the per-slave arbiter.
package ahb_arbiter_slave_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    BUSY   = 2'b01,
    NONSEQ = 2'b10,
    SEQ    = 2'b11
  } htrans_type;

  typedef enum logic [2:0] {
    SINGLE = 3'b000,
    INCR   = 3'b001,
    WRAP4  = 3'b010,
    INCR4  = 3'b011,
    WRAP8  = 3'b100,
    INCR8  = 3'b101,
    WRAP16 = 3'b110,
    INCR16 = 3'b111
  } hburst_type;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'b00,
    ARB_OWN   = 2'b01,
    ARB_UNDEF = 2'b10
  } arb_state_type;

  // Undefined-length INCR reports 0: it has no natural last beat.
  function automatic logic [4:0] burst_len(hburst_type burst);
    case (burst)
      SINGLE:        burst_len = 5'd1;
      WRAP4, INCR4:  burst_len = 5'd4;
      WRAP8, INCR8:  burst_len = 5'd8;
      WRAP16, INCR16: burst_len = 5'd16;
      default:       burst_len = 5'd0;
    endcase
  endfunction

endpackage

// File: rtl/ahb_arbiter_slave_rr_picker.sv
// Combinational round-robin search starting just after rr_ptr.
module ahb_rr_picker #(
  parameter int N      = 2,
  parameter int MIDX_W = 1
) (
  input  logic [N-1:0]      req,
  input  logic [MIDX_W-1:0] rr_ptr,
  output logic [MIDX_W-1:0] winner,
  output logic              winner_vld
);

  // NOTE: every output gets a default before the search so no path leaves
  // it unassigned, which would otherwise infer a latch.
  always_comb begin
    winner     = '0;
    winner_vld = 1'b0;
    // Offset N lands back on rr_ptr itself, so the last owner is tried last.
    for (int off = 1; off <= N; off++) begin
      int idx;
      idx = (int'(rr_ptr) + off) % N;
      if (!winner_vld && req[idx]) begin
        winner     = MIDX_W'(idx);
        winner_vld = 1'b1;
      end
    end
  end

endmodule

// File: rtl/ahb_arbiter_slave.sv
// Per-slave AHB arbiter: round-robin grant held for the length of a burst.
module ahb_arbiter_slave
  import ahb_arbiter_slave_pkg::*;
#(
  parameter int SLAVE_X_MASTER_NUM = 2,
  parameter int MIDX_W = (SLAVE_X_MASTER_NUM > 1) ? $clog2(SLAVE_X_MASTER_NUM) : 1
) (
  input  logic                                hclk,
  input  logic                                hreset_n,
  input  logic [SLAVE_X_MASTER_NUM-1:0]       hreq,
  input  logic [SLAVE_X_MASTER_NUM-1:0][1:0]  htrans_m,
  input  logic [SLAVE_X_MASTER_NUM-1:0][2:0]  hburst_m,
  input  logic                                hready_s,
  output logic [SLAVE_X_MASTER_NUM-1:0]       hgrant,
  output logic                                hsel,
  output logic [MIDX_W-1:0]                   hmaster_addr,
  output logic [MIDX_W-1:0]                   hmaster_data,
  output logic                                hmaster_data_vld
);

  arb_state_type                 state, state_d;
  logic [4:0]                    beat_cnt, cnt_d, cur_cnt;
  logic [MIDX_W-1:0]             rr_ptr, rr_d, addr_d, data_d, winner;
  logic [SLAVE_X_MASTER_NUM-1:0] grant_d, qreq;
  logic                          vld_d, winner_vld;
  logic                          own_req, xfer, first_nonseq, last_beat, window;
  htrans_type                    own_trans;
  hburst_type                    own_burst;

  assign own_req   = hreq[hmaster_addr];
  assign own_trans = htrans_type'(htrans_m[hmaster_addr]);
  assign own_burst = hburst_type'(hburst_m[hmaster_addr]);
  assign xfer      = (own_trans == NONSEQ) || (own_trans == SEQ);
  assign hsel      = (|hgrant) && own_req && (own_trans != IDLE);

  always_comb begin
    qreq = '0;
    for (int i = 0; i < SLAVE_X_MASTER_NUM; i++)
      qreq[i] = hreq[i] && (htrans_m[i] == NONSEQ);
  end

  ahb_rr_picker #(
    .N      (SLAVE_X_MASTER_NUM),
    .MIDX_W (MIDX_W)
  ) u_picker (
    .req        (qreq),
    .rr_ptr     (rr_ptr),
    .winner     (winner),
    .winner_vld (winner_vld)
  );

  // The first NONSEQ of a tenure counts as beat 1 of its own burst, so the
  // length is seen combinationally and a SINGLE releases on that same edge.
  assign first_nonseq = (state == ARB_OWN) && (beat_cnt == 5'd0) && (own_trans == NONSEQ);
  assign cur_cnt      = first_nonseq ? burst_len(own_burst) : beat_cnt;
  assign last_beat    = (state != ARB_IDLE) && (cur_cnt == 5'd1) && xfer;
  assign window       = hready_s && ((state == ARB_IDLE) || last_beat ||
                                     (own_trans == IDLE) || !own_req ||
                                     ((state == ARB_UNDEF) && (own_trans == NONSEQ)));

  always_comb begin
    state_d = state;
    cnt_d   = beat_cnt;
    rr_d    = rr_ptr;
    grant_d = hgrant;
    addr_d  = hmaster_addr;
    data_d  = hmaster_data;
    vld_d   = hmaster_data_vld;
    if (hready_s) begin
      data_d = hmaster_addr;
      vld_d  = hsel && xfer;
      if (window) begin
        cnt_d = '0;
        if (winner_vld) begin
          grant_d         = '0;
          grant_d[winner] = 1'b1;
          addr_d          = winner;
          rr_d            = winner;
          state_d         = ARB_OWN;
        end else begin
          grant_d = '0;
          state_d = ARB_IDLE;
        end
      end else if (xfer) begin
        cnt_d = (cur_cnt == 5'd0) ? 5'd0 : cur_cnt - 5'd1;
        if (first_nonseq && (own_burst == INCR))
          state_d = ARB_UNDEF;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge hclk) begin
    if (!hreset_n) begin
      state            <= ARB_IDLE;
      beat_cnt         <= '0;
      rr_ptr           <= '0;
      hgrant           <= '0;
      hmaster_addr     <= '0;
      hmaster_data     <= '0;
      hmaster_data_vld <= 1'b0;
    end else begin
      state            <= state_d;
      beat_cnt         <= cnt_d;
      rr_ptr           <= rr_d;
      hgrant           <= grant_d;
      hmaster_addr     <= addr_d;
      hmaster_data     <= data_d;
      hmaster_data_vld <= vld_d;
    end
  end

endmodule

// File: tb/tb_ahb_arbiter_slave.sv
// Directed bench for the two-master slave arbiter with hand-computed grants.
module tb_ahb_arbiter_slave;
  import ahb_arbiter_slave_pkg::*;

  localparam int N = 2;

  logic             hclk = 1'b0;
  logic             hreset_n;
  logic [N-1:0]     hreq;
  logic [N-1:0][1:0] htrans_m;
  logic [N-1:0][2:0] hburst_m;
  logic             hready_s;
  logic [N-1:0]     hgrant;
  logic             hsel;
  logic [0:0]       hmaster_addr, hmaster_data;
  logic             hmaster_data_vld;

  int checks = 0;
  int passed = 0;

  ahb_arbiter_slave #(.SLAVE_X_MASTER_NUM(N)) dut (
    .hclk             (hclk),
    .hreset_n         (hreset_n),
    .hreq             (hreq),
    .htrans_m         (htrans_m),
    .hburst_m         (hburst_m),
    .hready_s         (hready_s),
    .hgrant           (hgrant),
    .hsel             (hsel),
    .hmaster_addr     (hmaster_addr),
    .hmaster_data     (hmaster_data),
    .hmaster_data_vld (hmaster_data_vld)
  );

  always #5 hclk = ~hclk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge hclk);
    #1;
  endtask

  task automatic drive(input int m, input logic r, input htrans_type t, input hburst_type b);
    hreq[m]     = r;
    htrans_m[m] = t;
    hburst_m[m] = b;
  endtask

  task automatic do_reset();
    drive(0, 1'b0, IDLE, SINGLE);
    drive(1, 1'b0, IDLE, SINGLE);
    hready_s = 1'b1;
    hreset_n = 1'b0;
    tick();
    hreset_n = 1'b1;
  endtask

  task automatic check_grant(input string tag, input logic [1:0] g, input logic a);
    check({tag, "_grant"}, 32'(hgrant), 32'(g));
    check({tag, "_addr"}, 32'(hmaster_addr), 32'(a));
  endtask

  initial begin
    do_reset();
    check("rst_grant", 32'(hgrant), 32'd0);
    check("rst_addr", 32'(hmaster_addr), 32'd0);
    check("rst_data", 32'(hmaster_data), 32'd0);
    check("rst_vld", 32'(hmaster_data_vld), 32'd0);
    check("rst_fsm", 32'(dut.state), 32'(ARB_IDLE));

    // Requests with IDLE htrans never win.
    drive(0, 1'b1, IDLE, SINGLE);
    drive(1, 1'b1, IDLE, SINGLE);
    for (int i = 0; i < 4; i++) begin
      tick();
      check("idle_grant", 32'(hgrant), 32'd0);
      check("idle_hsel", 32'(hsel), 32'd0);
    end

    // Simultaneous SINGLEs: M1 first, then strict alternation.
    drive(0, 1'b1, NONSEQ, SINGLE);
    drive(1, 1'b1, NONSEQ, SINGLE);
    tick();
    check_grant("rr1", 2'b10, 1'b1);
    check("rr1_vld", 32'(hmaster_data_vld), 32'd0);
    check("rr1_hsel", 32'(hsel), 32'd1);
    tick();
    check_grant("rr2", 2'b01, 1'b0);
    check("rr2_data", 32'(hmaster_data), 32'd1);
    check("rr2_vld", 32'(hmaster_data_vld), 32'd1);
    tick();
    check_grant("rr3", 2'b10, 1'b1);
    check("rr3_data", 32'(hmaster_data), 32'd0);
    tick();
    check_grant("rr4", 2'b01, 1'b0);

    // INCR4 with one BUSY; M1 waits throughout.
    do_reset();
    drive(0, 1'b1, NONSEQ, INCR4);
    tick();
    check_grant("i4_own", 2'b01, 1'b0);
    drive(1, 1'b1, NONSEQ, SINGLE);
    tick();
    check_grant("i4_b1", 2'b01, 1'b0);
    drive(0, 1'b1, SEQ, INCR4);
    tick();
    check_grant("i4_b2", 2'b01, 1'b0);
    drive(0, 1'b1, BUSY, INCR4);
    tick();
    check_grant("i4_busy", 2'b01, 1'b0);
    check("i4_busy_vld", 32'(hmaster_data_vld), 32'd0);
    drive(0, 1'b1, SEQ, INCR4);
    tick();
    check_grant("i4_b3", 2'b01, 1'b0);
    check("i4_b3_vld", 32'(hmaster_data_vld), 32'd1);
    tick();
    check_grant("i4_b4", 2'b10, 1'b1);
    check("i4_b4_data", 32'(hmaster_data), 32'd0);
    check("i4_b4_vld", 32'(hmaster_data_vld), 32'd1);

    // Undefined-length INCR: six SEQ beats, released on IDLE.
    do_reset();
    drive(0, 1'b1, NONSEQ, INCR);
    tick();
    check_grant("inc_own", 2'b01, 1'b0);
    drive(1, 1'b1, NONSEQ, SINGLE);
    tick();
    check("inc_fsm", 32'(dut.state), 32'(ARB_UNDEF));
    drive(0, 1'b1, SEQ, INCR);
    for (int i = 0; i < 6; i++) begin
      tick();
      check("inc_hold", 32'(hgrant), 32'b01);
    end
    drive(0, 1'b1, IDLE, INCR);
    #1;
    check("inc_idle_hsel", 32'(hsel), 32'd0);
    tick();
    check_grant("inc_rel", 2'b10, 1'b1);
    check("inc_rel_vld", 32'(hmaster_data_vld), 32'd0);

    // WRAP8 owned by M1 with stalls on beat 1 and beat 4.
    do_reset();
    drive(1, 1'b1, NONSEQ, WRAP8);
    tick();
    check_grant("w8_own", 2'b10, 1'b1);
    check("w8_own_data", 32'(hmaster_data), 32'd0);
    drive(0, 1'b1, NONSEQ, SINGLE);
    hready_s = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_grant("w8_stall", 2'b10, 1'b1);
      check("w8_stall_data", 32'(hmaster_data), 32'd0);
      check("w8_stall_vld", 32'(hmaster_data_vld), 32'd0);
    end
    hready_s = 1'b1;
    tick();
    check("w8_b1_data", 32'(hmaster_data), 32'd1);
    check("w8_b1_vld", 32'(hmaster_data_vld), 32'd1);
    drive(1, 1'b1, SEQ, WRAP8);
    for (int b = 2; b <= 7; b++) begin
      if (b == 4) begin
        hready_s = 1'b0;
        tick();
        tick();
        check_grant("w8_stall2", 2'b10, 1'b1);
        hready_s = 1'b1;
      end
      tick();
      check_grant("w8_mid", 2'b10, 1'b1);
    end
    tick();
    check_grant("w8_b8", 2'b01, 1'b0);
    check("w8_b8_data", 32'(hmaster_data), 32'd1);

    // Early termination: owner drops hreq mid INCR8.
    do_reset();
    drive(0, 1'b1, NONSEQ, INCR8);
    tick();
    drive(1, 1'b1, NONSEQ, SINGLE);
    tick();
    drive(0, 1'b1, SEQ, INCR8);
    tick();
    check_grant("drop_hold", 2'b01, 1'b0);
    drive(0, 1'b0, SEQ, INCR8);
    tick();
    check_grant("drop_rel", 2'b10, 1'b1);

    // Reset on beat 3 of INCR16.
    do_reset();
    drive(0, 1'b1, NONSEQ, INCR16);
    tick();
    tick();
    drive(0, 1'b1, SEQ, INCR16);
    tick();
    check_grant("r16_b2", 2'b01, 1'b0);
    check("r16_b2_vld", 32'(hmaster_data_vld), 32'd1);
    hreset_n = 1'b0;
    tick();
    hreset_n = 1'b1;
    check_grant("r16_rst", 2'b00, 1'b0);
    check("r16_rst_vld", 32'(hmaster_data_vld), 32'd0);
    check("r16_rst_data", 32'(hmaster_data), 32'd0);
    check("r16_rst_fsm", 32'(dut.state), 32'(ARB_IDLE));
    check("r16_rst_hsel", 32'(hsel), 32'd0);
    tick();
    check("r16_seq_ignored", 32'(hgrant), 32'd0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/ahb_arbiter_slave.md
Name: ahb_arbiter_slave

Overview:
- Per-slave arbiter on the slave side of the AHB interconnect. Sits directly downstream of the per-master address decoders.
- Collects one hreq bit from each master's decoder (bit k of that decoder's hreq vector) and grants the slave to one master at a time.
- Arbitration is round-robin. A granted burst is held until it completes.
- Drives the address-phase and data-phase owner indices used by the slave-side address/data muxes.

Parameters:
- SLAVE_X_MASTER_NUM, 2, number of masters that can reach this slave (≥1).
- MIDX_W, $clog2(SLAVE_X_MASTER_NUM) (min 1), width of the master index.

Ports:
- hclk, input, 1, clock.
- hreset_n, input, 1, synchronous active-low reset.
- hreq, input, SLAVE_X_MASTER_NUM, per-master request from that master's decoder.
- htrans_m, input, SLAVE_X_MASTER_NUM x htrans_type, per-master htrans.
- hburst_m, input, SLAVE_X_MASTER_NUM x hburst_type, per-master hburst.
- hready_s, input, 1, slave hreadyout (transfer boundary).
- hgrant, output, SLAVE_X_MASTER_NUM, one-hot grant; all zero when unowned.
- hsel, output, 1, select to the slave.
- hmaster_addr, output, MIDX_W, address-phase owner index.
- hmaster_data, output, MIDX_W, data-phase owner index.
- hmaster_data_vld, output, 1, a data phase is in progress.

Behaviour:
- Reset (hreset_n=0 at a hclk edge): all registered outputs are 0; FSM=ARB_IDLE; beat_cnt=0; rr_ptr=0.
- Request qualification:
  - New request from master i = hreq[i] && htrans_m[i]==NONSEQ.
  - hreq with htrans IDLE or BUSY from a non-owner is ignored (the decoder can assert hreq while IDLE).
- Round-robin winner: the first qualified requester searching from rr_ptr+1 upward, wrapping modulo SLAVE_X_MASTER_NUM. rr_ptr is updated to the winner on grant.
- Arbitration window is open when hready_s=1 AND one of:
  - FSM=ARB_IDLE;
  - the owner is on its last beat (beat_cnt==1 and owner htrans is NONSEQ or SEQ);
  - the owner drives IDLE;
  - the owner drops hreq.
- Grant: at a hclk edge with the window open and a winner present, hgrant becomes onehot(winner) and hmaster_addr=winner. No winner → hgrant=0, hmaster_addr holds its value, FSM=ARB_IDLE. Latency is 1 cycle from qualified request to hgrant.
- hready_s=0 freezes hgrant, hmaster_addr, hmaster_data, beat_cnt and FSM.
- FSM:
  - ARB_IDLE: on grant → ARB_OWN.
  - ARB_OWN: on the owner's first accepted NONSEQ (hready_s=1), load beat_cnt from hburst:
    - SINGLE → 1
    - INCR4/WRAP4 → 4
    - INCR8/WRAP8 → 8
    - INCR16/WRAP16 → 16
    - INCR → 0, and go to ARB_UNDEF
  - ARB_OWN / ARB_UNDEF: decrement beat_cnt on each accepted NONSEQ or SEQ beat. BUSY does not decrement and holds ownership.
  - ARB_UNDEF: holds while the owner keeps hreq=1 and drives SEQ or BUSY. Released when the owner drives IDLE or a new NONSEQ, or drops hreq.
  - Release: go to ARB_OWN if a new winner is granted in the same cycle, otherwise ARB_IDLE.
- Simultaneous release and new request: rearbitration happens in the same cycle, with no idle gap. The previous owner takes part, but round-robin places it last.
- Owner drops hreq mid fixed-length burst (early termination): release at the next hready_s=1 edge; beat_cnt is cleared.
- hsel (combinational) = |hgrant && hreq[hmaster_addr] && htrans_m[hmaster_addr]!=IDLE.
- Data phase: on a hclk edge with hready_s=1:
  - hmaster_data <= hmaster_addr;
  - hmaster_data_vld <= hsel && htrans_m[owner] in {NONSEQ, SEQ}.
- Width rule: beat_cnt is 5 bits and saturates at 0 (no wrap below 0).
- Reset mid-burst: all state is cleared at the edge regardless of hready_s.

Decomposition:
- AHB_package owns: htrans_type (IDLE/BUSY/NONSEQ/SEQ), hburst_type (SINGLE/INCR/WRAP4/INCR4/WRAP8/INCR8/WRAP16/INCR16), arb_state_type (ARB_IDLE/ARB_OWN/ARB_UNDEF), and a function burst_len(hburst_type) returning 5 bits.
- One sub-module, ahb_rr_picker: combinational round-robin search, with inputs req and rr_ptr and outputs winner and winner_vld. Instantiated once.

Test Plan:
- Reset, then both masters idle with hreq=1 and htrans=IDLE → hgrant=00 and hsel=0 indefinitely.
- M0 and M1 both assert NONSEQ SINGLE in the same cycle after reset (rr_ptr=0) → M1 is granted first (hgrant=10). M0 is granted at the next hready_s=1 edge. Grants then alternate 1,0,1,0.
- M0 does INCR4 with a BUSY inserted after beat 2, while M1 requests throughout → M0 holds for 4 accepted beats plus 1 BUSY cycle. hgrant switches to M1 on the edge of beat 4.
- M0 does INCR (undefined length), 6 SEQ beats then IDLE → ownership is held for all 6 beats; release and M1 grant on the IDLE edge.
- hready_s held low for 3 cycles mid-WRAP8 → hgrant, hmaster_addr and hmaster_data are unchanged and beat_cnt is frozen; the count resumes when hready_s returns.
- hreset_n=0 for 1 cycle on beat 3 of INCR16 → the next cycle has hgrant=0, hmaster_data_vld=0 and FSM=ARB_IDLE.
